// File: rtl/spi_slave_core.sv
// SPI responder with oversampled SCLK/CS_N/MOSI, all four CPOL/CPHA modes.
// Words are MSB first; back-to-back words allowed under one chip select.
module spi_slave_core #(
   parameter int BITNUM   = 16,
   parameter int SYNC_STG = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              CPOL,
   input  logic              CPHA,
   input  logic              SCLK,
   input  logic              CS_N,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   input  logic [BITNUM-1:0] tx_data,
   output logic              tx_ack,
   output logic [BITNUM-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CW = (BITNUM > 1) ? $clog2(BITNUM) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ACTIVE
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STG-1:0] sclk_sync;
   logic [SYNC_STG-1:0] cs_sync;
   logic [SYNC_STG-1:0] mosi_sync;
   logic                s_sclk, s_cs_n, s_mosi;
   logic                sclk_q, cs_q;
   logic                cpol_q, cpha_q;
   logic [CW-1:0]       bit_cnt;
   logic [BITNUM-1:0]   tx_shift;
   logic [BITNUM-1:0]   rx_shift;
   logic                word_done;

   logic sclk_chg, lead, trail;
   logic sample_e, shift_e;
   logic cs_fall, cs_rise;
   logic last_bit;

   // Bring the asynchronous SPI pins into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STG-2:0], SCLK};
         cs_sync   <= {cs_sync[SYNC_STG-2:0], CS_N};
         mosi_sync <= {mosi_sync[SYNC_STG-2:0], MOSI};
         sclk_q    <= s_sclk;
         cs_q      <= s_cs_n;
      end
   end

   assign s_sclk = sclk_sync[SYNC_STG-1];
   assign s_cs_n = cs_sync[SYNC_STG-1];
   assign s_mosi = mosi_sync[SYNC_STG-1];

   assign sclk_chg = s_sclk ^ sclk_q;
   assign lead     = sclk_chg & (s_sclk != cpol_q);
   assign trail    = sclk_chg & (s_sclk == cpol_q);
   assign sample_e = cpha_q ? trail : lead;
   assign shift_e  = cpha_q ? lead : trail;
   assign cs_fall  = cs_q & ~s_cs_n;
   assign cs_rise  = ~cs_q & s_cs_n;
   assign last_bit = (bit_cnt == CW'(BITNUM - 1));
   assign busy     = (state_q != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; a CS_N rise always takes priority
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cs_fall) state_d = LOAD;
         LOAD:    state_d = cs_rise ? IDLE : ACTIVE;
         ACTIVE:  if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shift registers, bit counter and the output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         bit_cnt   <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         word_done <= 1'b0;
         MISO      <= 1'b0;
         MISO_OE   <= 1'b0;
         tx_ack    <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         tx_ack    <= 1'b0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         word_done <= 1'b0;
         if (word_done) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  cpol_q   <= CPOL;
                  cpha_q   <= CPHA;
                  bit_cnt  <= '0;
                  tx_shift <= tx_data;
                  tx_ack   <= 1'b1;
               end
            end
            LOAD: begin
               if (!cs_rise) begin
                  MISO_OE <= 1'b1;
                  MISO    <= tx_shift[BITNUM-1];
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  MISO_OE   <= 1'b0;
                  MISO      <= 1'b0;
                  frame_err <= (bit_cnt != '0);
               end else if (sample_e) begin
                  rx_shift <= {rx_shift[BITNUM-2:0], s_mosi};
                  if (last_bit) begin
                     bit_cnt   <= '0;
                     word_done <= 1'b1;
                     tx_shift  <= tx_data;
                     tx_ack    <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (shift_e) begin
                  // At bit 0 the MSB of the current word is presented unshifted
                  if (bit_cnt == '0) begin
                     MISO <= tx_shift[BITNUM-1];
                  end else begin
                     tx_shift <= tx_shift << 1;
                     MISO     <= tx_shift[BITNUM-2];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_core.sv
// Testbench for spi_slave_core: behavioural SPI master plus word-level
// reference (sent words must come back in order on both sides).
module tb_spi_slave_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        CPOL = 1'b0;
   logic        CPHA = 1'b0;
   logic        SCLK = 1'b0;
   logic        CS_N = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO, MISO_OE;
   logic [15:0] tx_data = '0;
   logic        tx_ack;
   logic [15:0] rx_data;
   logic        rx_valid, frame_err, busy;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] m_words[$];
   logic [15:0] s_words[$];
   logic [15:0] rd_words[$];
   logic [15:0] rx_q[$];
   int          ack_cnt = 0;
   int          ferr_cnt = 0;
   logic [15:0] last_rx = '0;

   spi_slave_core #(.BITNUM(16), .SYNC_STG(2)) dut (
      .clk(clk), .rst_n(rst_n), .CPOL(CPOL), .CPHA(CPHA),
      .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE),
      .tx_data(tx_data), .tx_ack(tx_ack),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Record DUT pulses away from the active edge
   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_ack) ack_cnt++;
      if (frame_err) ferr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic half(input bit jit);
      int n;
      n = jit ? int'($urandom_range(3, 5)) : 4;
      repeat (n) @(negedge clk);
   endtask

   // Master side: nbits clocked out; rst_bit >= 0 pulses reset there
   task automatic spi_xfer(input bit pol, input bit pha, input int nbits,
                           input bit jit, input int rst_bit);
      logic [15:0] rd;
      int w, b;
      rd = '0;
      rd_words.delete();
      CPOL = pol;
      CPHA = pha;
      SCLK = pol;
      if (s_words.size() > 0) tx_data = s_words[0];
      repeat (4) @(negedge clk);
      CS_N = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         w = i / 16;
         b = 15 - (i % 16);
         if (i == rst_bit) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            chk("rst_miso", 32'(MISO), 0);
            chk("rst_oe", 32'(MISO_OE), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rxd", 32'(rx_data), 0);
            chk("rst_pulses", {29'd0, rx_valid, tx_ack, frame_err}, 0);
            CS_N = 1'b1;
            SCLK = pol;
            repeat (4) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            return;
         end
         if (!pha) begin
            MOSI = m_words[w][b];
            half(jit);
            rd[b] = MISO;
            SCLK = ~pol;
            half(jit);
            SCLK = pol;
         end else begin
            SCLK = ~pol;
            MOSI = m_words[w][b];
            half(jit);
            rd[b] = MISO;
            SCLK = pol;
            half(jit);
         end
         if (b == 0) rd_words.push_back(rd);
         if (b == 15 && s_words.size() > w + 1) tx_data = s_words[w + 1];
      end
      repeat (4) @(negedge clk);
      CS_N = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Full-word frame compared against the word lists
   task automatic run_frame(input string tag, input bit pol, input bit pha,
                            input bit jit);
      int rx0, ack0, fe0, n;
      rx0 = rx_q.size();
      ack0 = ack_cnt;
      fe0 = ferr_cnt;
      n = m_words.size();
      spi_xfer(pol, pha, 16 * n, jit, -1);
      chk({tag, "_rxcnt"}, 32'(rx_q.size() - rx0), 32'(n));
      chk({tag, "_rdcnt"}, 32'(rd_words.size()), 32'(n));
      for (int k = 0; k < n; k++) begin
         if (rx0 + k < rx_q.size())
            chk({tag, "_rx"}, 32'(rx_q[rx0 + k]), 32'(m_words[k]));
         if (k < rd_words.size())
            chk({tag, "_miso"}, 32'(rd_words[k]), 32'(s_words[k]));
      end
      chk({tag, "_ack"}, 32'(ack_cnt - ack0), 32'(n + 1));
      chk({tag, "_ferr"}, 32'(ferr_cnt - fe0), 0);
      chk({tag, "_oe"}, 32'(MISO_OE), 0);
      last_rx = m_words[n - 1];
   endtask

   initial begin
      int fe0, rx0, nw, left;
      repeat (3) @(negedge clk);
      chk("reset_oe", 32'(MISO_OE), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rxd", 32'(rx_data), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      m_words = '{16'hA5C3};
      s_words = '{16'h3C5A};
      run_frame("mode0", 1'b0, 1'b0, 1'b0);
      chk("mode0_rxd", 32'(rx_data), 32'h0000A5C3);

      for (int m = 1; m < 4; m++) begin
         m_words = '{16'h8001};
         s_words = '{16'hFFFE};
         run_frame($sformatf("mode%0d", m), m[1], m[0], 1'b0);
      end

      m_words = '{16'h1234, 16'hABCD};
      s_words = '{16'h5A5A, 16'hC0DE};
      run_frame("two", 1'b0, 1'b1, 1'b0);

      fe0 = ferr_cnt;
      rx0 = rx_q.size();
      m_words = '{16'hFFFF};
      s_words = '{16'h1111};
      spi_xfer(1'b0, 1'b0, 7, 1'b0, -1);
      chk("abort_ferr", 32'(ferr_cnt - fe0), 1);
      chk("abort_rxcnt", 32'(rx_q.size() - rx0), 0);
      chk("abort_rxd", 32'(rx_data), 32'(last_rx));
      chk("abort_oe", 32'(MISO_OE), 0);

      fe0 = ferr_cnt;
      rx0 = rx_q.size();
      m_words = '{16'hF0F0};
      s_words = '{16'h2222};
      spi_xfer(1'b0, 1'b0, 16, 1'b0, 5);
      chk("rst_ferr", 32'(ferr_cnt - fe0), 0);
      chk("rst_rxcnt", 32'(rx_q.size() - rx0), 0);
      m_words = '{16'h0F0F};
      s_words = '{16'h9669};
      run_frame("after_rst", 1'b0, 1'b0, 1'b0);

      left = 200;
      while (left > 0) begin
         nw = $urandom_range(1, 3);
         if (nw > left) nw = left;
         m_words.delete();
         s_words.delete();
         for (int k = 0; k < nw; k++) begin
            m_words.push_back(16'($urandom));
            s_words.push_back(16'($urandom));
         end
         run_frame("rand", 1'($urandom), 1'($urandom), 1'b1);
         left -= nw;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
